// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: single-cycle registered multiply,
// 32-step radix-2 restoring divide on magnitudes, flush abort, one-cycle done pulse.
module muldiv_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        ready,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W   = 32;
  localparam int unsigned CW  = 6;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sgn_q;
  logic [W-1:0]  a_q, b_q;
  logic [W-1:0]  rem, quo, dvs;

  // Operand magnitudes taken at accept; op[0]=0 selects the signed variants
  logic          sgn_in;
  logic [W-1:0]  a_mag, b_mag;
  assign sgn_in = ~op[0];
  assign a_mag  = (sgn_in && a[W-1]) ? (~a + W'(1)) : a;
  assign b_mag  = (sgn_in && b[W-1]) ? (~b + W'(1)) : b;

  logic [2*W-1:0] prod_s, prod_u;
  assign prod_s = $signed({{W{a_q[W-1]}}, a_q}) * $signed({{W{b_q[W-1]}}, b_q});
  assign prod_u = {W'(0), a_q} * {W'(0), b_q};

  // One restoring-division step: shift in the next dividend bit, subtract if it fits
  logic [W:0]   shifted, diff;
  logic [W-1:0] rem_nxt, quo_nxt;
  always_comb begin
    shifted = {rem, quo[W-1]};
    diff    = shifted - {1'b0, dvs};
    rem_nxt = shifted[W-1:0];
    quo_nxt = {quo[W-2:0], 1'b0};
    if (!diff[W]) begin
      rem_nxt = diff[W-1:0];
      quo_nxt = {quo[W-2:0], 1'b1};
    end
  end

  // Sign fix-up after the final step; divide by zero bypasses it
  logic         neg_q, neg_r;
  logic [W-1:0] q_res, r_res;
  always_comb begin
    neg_q = sgn_q & (a_q[W-1] ^ b_q[W-1]);
    neg_r = sgn_q & a_q[W-1];
    q_res = neg_q ? (~quo_nxt + W'(1)) : quo_nxt;
    r_res = neg_r ? (~rem_nxt + W'(1)) : rem_nxt;
    if (b_q == '0) begin
      q_res = '1;
      r_res = a_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      sgn_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      ready <= 1'b1;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        cnt   <= '0;
        ready <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (valid) begin
              sgn_q <= sgn_in;
              a_q   <= a;
              b_q   <= b;
              rem   <= '0;
              quo   <= a_mag;
              dvs   <= b_mag;
              cnt   <= '0;
              ready <= 1'b0;
              state <= op[1] ? DIV : MUL;
            end
          end
          MUL: begin
            {hi, lo} <= sgn_q ? prod_s : prod_u;
            done     <= 1'b1;
            state    <= DONE;
          end
          DIV: begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
              hi    <= r_res;
              lo    <= q_res;
              done  <= 1'b1;
              cnt   <= '0;
              state <= DONE;
            end
          end
          DONE: begin
            ready <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: latency/result model checked every cycle, directed literal
// cases for sign rules, divide-by-zero, overflow wrap, flush and reset, then random traffic.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        valid = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        ready, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk(clk), .resetn(resetn), .valid(valid), .op(op), .a(a), .b(b),
    .flush(flush), .ready(ready), .done(done), .hi(hi), .lo(lo)
  );

  // Expected {hi, lo} straight from the arithmetic definition of each op
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, y);
    longint sx, sy, q, r;
    logic [63:0] p;
    case (o)
      2'd0: begin
        sx = longint'($signed(x)); sy = longint'($signed(y));
        p = 64'(sx * sy);
      end
      2'd1: p = {32'd0, x} * {32'd0, y};
      default: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else begin
          if (o == 2'd2) begin sx = longint'($signed(x)); sy = longint'($signed(y)); end
          else begin sx = longint'({32'd0, x}); sy = longint'({32'd0, y}); end
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  // Cycle-level model: idle -> busy for the op latency -> one done cycle -> idle
  typedef enum {M_IDLE, M_BUSY, M_DONE} mphase_t;
  mphase_t     ph = M_IDLE;
  int          left = 0;
  logic [63:0] pend = 64'd0;
  logic        m_ready = 1'b1, m_done = 1'b0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ph = M_IDLE; left = 0; m_ready = 1'b1; m_done = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
    end else begin
      m_done = 1'b0;
      if (flush) begin
        ph = M_IDLE; m_ready = 1'b1;
      end else begin
        case (ph)
          M_IDLE: if (valid) begin
            pend = ref_result(op, a, b);
            left = (op[1] ? 33 : 2) - 1;
            ph = M_BUSY; m_ready = 1'b0;
          end
          M_BUSY: begin
            left--;
            if (left == 0) begin
              m_done = 1'b1; {m_hi, m_lo} = pend; ph = M_DONE;
            end
          end
          M_DONE: begin ph = M_IDLE; m_ready = 1'b1; end
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      check("model_ready", 32'(ready), 32'(m_ready));
      check("model_done",  32'(done),  32'(m_done));
      check("model_hi",    hi, m_hi);
      check("model_lo",    lo, m_lo);
    end
  end

  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    valid = 1'b1; op = o; a = x; b = y;
  endtask

  // Accept happens on the next posedge; lat counts cycles from accept to the done cycle
  task automatic wait_done(input bit hold, output int lat);
    lat = 0;
    @(posedge clk);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (hold) begin a = $urandom; b = $urandom; end
      else valid = 1'b0;
      if (done) begin lat = k; break; end
    end
    valid = 1'b0;
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL done_timeout cycle %0d: got no done want done within 100", cyc);
    end
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit hold, output logic [31:0] rh, output logic [31:0] rl,
                       output int lat);
    @(negedge clk);
    start_op(o, x, y);
    wait_done(hold, lat);
    rh = hi; rl = lo;
  endtask

  task automatic run_directed(input string name, input logic [1:0] o, input logic [31:0] x,
                              input logic [31:0] y, input int elat,
                              input logic [31:0] ehi, input logic [31:0] elo);
    logic [31:0] rh, rl;
    int lat;
    do_op(o, x, y, 1'b0, rh, rl, lat);
    check({name, "_lat"}, 32'(lat), 32'(elat));
    check({name, "_hi"}, rh, ehi);
    check({name, "_lo"}, rl, elo);
  endtask

  // Advance to cycle k (k=1 is the first cycle after accept) of an already-started op
  task automatic run_to(input int k);
    @(posedge clk);
    for (int i = 1; i <= k; i++) begin
      @(negedge clk);
      valid = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] rh, rl;
    int lat;

    #2 resetn = 1'b0;
    #1 chk_en = 1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done",  32'(done),  32'd0);
    check("rst_hi",    hi, 32'd0);
    check("rst_lo",    lo, 32'd0);
    repeat (2) @(negedge clk);

    // First accept lands on the first rising edge after release
    resetn = 1'b1;
    start_op(2'd0, 32'hFFFF_FFFE, 32'd3);
    wait_done(1'b0, lat);
    check("mult_first_lat", 32'(lat), 32'd2);
    check("mult_first_hi", hi, 32'hFFFF_FFFF);
    check("mult_first_lo", lo, 32'hFFFF_FFFA);

    run_directed("multu",   2'd1, 32'hFFFF_FFFE, 32'd3,         2,  32'h0000_0002, 32'hFFFF_FFFA);
    run_directed("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_directed("divu",    2'd3, 32'd100,       32'd7,         33, 32'd2,         32'd14);
    run_directed("divu_z",  2'd3, 32'h1234_5678, 32'd0,         33, 32'h1234_5678, 32'hFFFF_FFFF);
    run_directed("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0,         32'h8000_0000);
    run_directed("div_z",   2'd2, 32'hFFFF_FFFB, 32'd0,         33, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

    // valid held with changing operands: result from captured operands, one done only
    do_op(2'd2, 32'd1000, 32'hFFFF_FFFD, 1'b1, rh, rl, lat);
    check("hold_lat", 32'(lat), 32'd33);
    check("hold_hi", rh, 32'd1);
    check("hold_lo", rl, 32'hFFFF_FEB3);
    @(negedge clk);
    check("hold_ready_after", 32'(ready), 32'd1);

    // Flush at cycle 10 of a divide
    @(negedge clk);
    start_op(2'd2, 32'd50, 32'd7);
    run_to(10);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready", 32'(ready), 32'd1);
    check("flush_hi", hi, 32'd1);
    check("flush_lo", lo, 32'hFFFF_FEB3);
    run_directed("mult_5x6", 2'd0, 32'd5, 32'd6, 2, 32'd0, 32'd30);

    // Flush in the last divide cycle suppresses done and the result write
    @(negedge clk);
    start_op(2'd3, 32'd9, 32'd2);
    run_to(32);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("lateflush_done", 32'(done), 32'd0);
    check("lateflush_lo", lo, 32'd30);

    // Reset in cycle 5 of a divide
    @(negedge clk);
    start_op(2'd2, 32'd77, 32'd5);
    run_to(5);
    #2 resetn = 1'b0;
    #1;
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("midrst_ready", 32'(ready), 32'd1);
    repeat (40) @(negedge clk);

    // Random traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      valid = ($urandom_range(0, 2) != 0);
      op    = 2'($urandom_range(0, 3));
      a     = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 20));
        default: b = 32'($urandom);
      endcase
      flush = ($urandom_range(0, 59) == 0);
    end
    @(negedge clk);
    valid = 1'b0; flush = 1'b0;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
